vga_text_console: RTL and testbench
===================================

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 25, text rows on screen.
REQ-003 Parameter BLANK, default 8'h20, fill code used for clear and scroll.
REQ-004 vclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on vclk.
REQ-006 char_in  input  8  byte from the host stream.
REQ-007 char_valid  input  1  char_in holds a valid byte.
REQ-008 char_ready  output  1  block accepts a byte this cycle.
REQ-009 addr  output  12  video RAM address; cell index = row*COLS+col.
REQ-010 dout  output  8  write data to video RAM din.
REQ-011 we  output  1  video RAM write strobe, one cycle per write.
REQ-012 din  input  8  video RAM read data; valid one cycle after addr is presented.
REQ-013 cur_col  output  7  current cursor column.
REQ-014 cur_row  output  5  current cursor row.

Function
REQ-015 Transfer SHALL occur only when char_valid and char_ready are both high on the same edge.
REQ-016 char_ready SHALL be high only in state IDLE; it SHALL be low during the cycle after any accepted byte.
REQ-017 States SHALL be IDLE, PUT, SCR_RD, SCR_WR, CLR.
REQ-018 Printable byte (0x20-0x7E, 0x80-0xFF) SHALL go IDLE->PUT; PUT drives addr=cur_row*COLS+cur_col, dout=byte, we=1 for exactly one cycle, then advances the cursor and returns to IDLE.
REQ-019 Cursor advance: col+1; at col=COLS-1, col wraps to 0 and row+1; at row=ROWS-1, row stays ROWS-1 and the state enters SCR_RD.
REQ-020 0x0D (CR) SHALL set col=0 with no RAM access; the block returns to IDLE the next cycle.
REQ-021 0x0A (LF) SHALL set row+1 with col unchanged; at row=ROWS-1, row is unchanged and the state enters SCR_RD.
REQ-022 0x08 (BS) SHALL decrement col if col>0, without erasing; at col=0 it SHALL do nothing.
REQ-023 0x0C (FF) SHALL enter CLR and set the cursor to (0,0).
REQ-024 All other bytes below 0x20 SHALL be consumed and ignored.
REQ-025 Scroll SHALL use index i from 0 to (ROWS-1)*COLS-1: SCR_RD drives addr=i+COLS with we=0; the next cycle, SCR_WR drives addr=i, dout=din, we=1; the cycle cost is 2 per cell.
REQ-026 After the last SCR_WR, cells (ROWS-1)*COLS .. ROWS*COLS-1 SHALL be written with BLANK at one cell per cycle, then the block returns to IDLE.
REQ-027 CLR SHALL write BLANK to cells 0 .. ROWS*COLS-1 at one per cycle, ascending, then return to IDLE.
REQ-028 addr SHALL never exceed ROWS*COLS-1; all address arithmetic is 12-bit unsigned with no wrap.
REQ-029 When not writing, we SHALL be 0; addr and dout hold their last values.
REQ-030 char_valid asserted during scroll or clear SHALL be held off by char_ready=0; no byte is lost or duplicated.

Reset
REQ-031 With rst high: cursor=(0,0), we=0, addr=0, dout=BLANK, char_ready=0.
REQ-032 On rst release, the state SHALL be CLR; the screen is fully blanked (COLS*ROWS cycles) before char_ready first rises.
REQ-033 rst asserted mid-scroll or mid-write SHALL abort immediately; no further write from the aborted operation SHALL occur, and REQ-032 applies.

Verification
REQ-034 Release rst -> exactly 2000 we pulses with dout=0x20 at addr 0..1999 ascending, then char_ready=1, cursor=(0,0).
REQ-035 Send "A" (0x41) from (0,0) -> one write at addr 0 with dout=0x41; cursor becomes (1,0); char_ready is low for one cycle.
REQ-036 Cursor at (79,3), send 0x42 -> write at addr 319; cursor becomes (0,4).
REQ-037 Preload row 1 with 0x31, cursor at (5,24), send 0x0A -> row 0 holds 0x31 and row 24 holds 0x20; scroll length is 3920 cycles; cursor becomes (5,24).
REQ-038 Send 0x0D, 0x08 at col 0, 0x07, and 0x0C in sequence -> col=0, col stays 0, no RAM write, then 2000-cell clear with cursor (0,0).
REQ-039 Assert rst for one cycle at scroll index 500 -> the last scroll write is at or before addr 500, then a full clear runs.

Source files
------------

// File: rtl/vga_text_console.sv
// Text-mode console writer: turns a host byte stream into video RAM writes,
// with cursor tracking, one-row scroll and full-screen clear.
module vga_text_console #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 25,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [11:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    input  logic [7:0]  din,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row
);

    // state  | meaning
    // IDLE   | waiting for a host byte (only state with char_ready high)
    // PUT    | act on the accepted byte: write printable cell or move cursor
    // SCR_RD | scroll: read cell idx+COLS
    // SCR_WR | scroll: write din back to cell idx
    // CLR    | write BLANK to cell idx, one cell per cycle
    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;

    localparam logic [11:0] COLS12    = 12'(COLS);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [11:0] SCR_CELLS = 12'((ROWS - 1) * COLS);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    state_t      state, state_nxt;
    logic [7:0]  byte_q;
    logic [11:0] idx, idx_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic [6:0]  col_nxt;
    logic [4:0]  row_nxt;
    logic [11:0] addr_q;
    logic [7:0]  dout_q;
    logic        printable;
    logic        accept;
    logic        scroll;

    assign printable  = (byte_q >= 8'h20) && (byte_q != 8'h7F);
    assign char_ready = (state == IDLE) && !rst;
    assign accept     = char_valid && char_ready;

    always_ff @(posedge vclk) begin
        if (rst) begin
            state   <= CLR;
            idx     <= '0;
            cnt     <= LAST_CELL;
            cur_col <= '0;
            cur_row <= '0;
            addr_q  <= '0;
            dout_q  <= BLANK;
            byte_q  <= BLANK;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            cur_col <= col_nxt;
            cur_row <= row_nxt;
            addr_q  <= addr;
            dout_q  <= dout;
            if (accept)
                byte_q <= char_in;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        col_nxt   = cur_col;
        row_nxt   = cur_row;
        addr      = addr_q;
        dout      = dout_q;
        we        = 1'b0;
        scroll    = 1'b0;

        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = PUT;
            end
            PUT: begin
                state_nxt = IDLE;
                if (printable) begin
                    addr = 12'(cur_row) * COLS12 + 12'(cur_col);
                    dout = byte_q;
                    we   = 1'b1;
                    if (cur_col == LAST_COL) begin
                        col_nxt = '0;
                        if (cur_row == LAST_ROW)
                            scroll = 1'b1;
                        else
                            row_nxt = cur_row + 5'd1;
                    end else begin
                        col_nxt = cur_col + 7'd1;
                    end
                end else begin
                    case (byte_q)
                        8'h0D: col_nxt = '0;
                        8'h0A: begin
                            if (cur_row == LAST_ROW)
                                scroll = 1'b1;
                            else
                                row_nxt = cur_row + 5'd1;
                        end
                        8'h08: begin
                            if (cur_col != 7'd0)
                                col_nxt = cur_col - 7'd1;
                        end
                        8'h0C: begin
                            col_nxt   = '0;
                            row_nxt   = '0;
                            idx_nxt   = '0;
                            cnt_nxt   = LAST_CELL;
                            state_nxt = CLR;
                        end
                        default: ;
                    endcase
                end
                if (scroll) begin
                    idx_nxt   = '0;
                    cnt_nxt   = SCR_CELLS - 12'd1;
                    state_nxt = SCR_RD;
                end
            end
            SCR_RD: begin
                addr      = idx + COLS12;
                state_nxt = SCR_WR;
            end
            SCR_WR: begin
                // din answers the address presented in the preceding SCR_RD cycle
                addr = idx;
                dout = din;
                we   = 1'b1;
                if (cnt == 12'd0) begin
                    idx_nxt   = SCR_CELLS;
                    cnt_nxt   = COLS12 - 12'd1;
                    state_nxt = CLR;
                end else begin
                    idx_nxt   = idx + 12'd1;
                    cnt_nxt   = cnt - 12'd1;
                    state_nxt = SCR_RD;
                end
            end
            CLR: begin
                addr = idx;
                dout = BLANK;
                we   = 1'b1;
                if (cnt == 12'd0) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 12'd1;
                    cnt_nxt = cnt - 12'd1;
                end
            end
            default: state_nxt = CLR;
        endcase

        // reset cancels the current cycle's write at once
        if (rst) begin
            addr = '0;
            dout = BLANK;
            we   = 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboarded bench for vga_text_console: expected RAM writes are queued by the
// stimulus and popped by a monitor on every write strobe.
module tb_vga_text_console;

    logic        vclk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [11:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [7:0]  din;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    logic [7:0]  mem     [0:4095];
    logic [7:0]  exp_mem [0:4095];
    logic [19:0] sb_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    vga_text_console dut (
        .vclk       (vclk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .addr       (addr),
        .dout       (dout),
        .we         (we),
        .din        (din),
        .cur_col    (cur_col),
        .cur_row    (cur_row)
    );

    always #5 vclk = ~vclk;

    // synchronous video RAM: read data appears the cycle after the address
    always @(posedge vclk) begin
        if (we)
            mem[addr] <= dout;
        din <= mem[addr];
    end

    always @(negedge vclk) begin
        logic [19:0] e;
        if (we) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0d dout=%h, required no write", addr, dout);
            end else begin
                e = sb_q.pop_front();
                if ({addr, dout} !== e) begin
                    miscompares++;
                    $display("FAIL ram_write: got addr=%0d dout=%h, required addr=%0d dout=%h",
                             addr, dout, e[19:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_w(input int a, input logic [7:0] d);
        sb_q.push_back({12'(a), d});
        exp_mem[a] = d;
    endtask

    task automatic push_clear();
        for (int i = 0; i < 2000; i++)
            push_w(i, 8'h20);
    endtask

    task automatic push_scroll(input int cells);
        for (int i = 0; i < cells; i++)
            push_w(i, exp_mem[i + 80]);
        if (cells == 1920)
            for (int i = 1920; i < 2000; i++)
                push_w(i, 8'h20);
    endtask

    task automatic wait_ready(input int limit);
        for (int i = 0; i < limit && char_ready !== 1'b1; i++) begin
            @(posedge vclk);
            #1;
        end
        chk("ready_within_bound", char_ready, 1);
    endtask

    task automatic send(input logic [7:0] b);
        char_in    = b;
        char_valid = 1'b1;
        wait_ready(5000);
        @(posedge vclk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_idle(input logic [7:0] b);
        send(b);
        wait_ready(5000);
    endtask

    task automatic chk_cur(input string name, input int col, input int row);
        chk({name, "_col"}, cur_col, col);
        chk({name, "_row"}, cur_row, row);
    endtask

    initial begin
        #3000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        bit started;
        bit found;

        // reset values, then the power-up clear with 'A' held pending throughout
        push_clear();
        push_w(0, 8'h41);
        repeat (3) @(posedge vclk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dout", dout, 8'h20);
        chk("rst_ready", char_ready, 0);
        chk_cur("rst", 0, 0);
        rst        = 1'b0;
        char_in    = 8'h41;
        char_valid = 1'b1;
        wait_ready(2100);
        chk_cur("clr_done", 0, 0);
        chk("clr_pending", sb_q.size(), 1);
        @(posedge vclk);
        #1;
        char_valid = 1'b0;
        chk("a_ready_low", char_ready, 0);
        @(posedge vclk);
        #1;
        chk("a_ready_back", char_ready, 1);
        chk_cur("after_a", 1, 0);
        chk("a_queue", sb_q.size(), 0);

        // end-of-row wrap: (79,3) -> write 319 -> (0,4)
        send_idle(8'h0D);
        chk_cur("cr", 0, 0);
        repeat (3) send_idle(8'h0A);
        for (int k = 0; k < 79; k++) begin
            push_w(240 + k, 8'h62);
            send_idle(8'h62);
        end
        chk_cur("at_79_3", 79, 3);
        push_w(319, 8'h42);
        send_idle(8'h42);
        chk_cur("wrap", 0, 4);

        // control codes: CR, BS at col 0, BEL ignored, BS at col 2, FF clear
        push_w(320, 8'h63);
        send_idle(8'h63);
        send_idle(8'h0D);
        chk_cur("cr_mid", 0, 4);
        send_idle(8'h08);
        chk_cur("bs_col0", 0, 4);
        send_idle(8'h07);
        chk_cur("bel", 0, 4);
        push_w(320, 8'h64);
        push_w(321, 8'h64);
        send_idle(8'h64);
        send_idle(8'h64);
        send_idle(8'h08);
        chk_cur("bs_col2", 1, 4);
        push_clear();
        send(8'h0C);
        wait_ready(2100);
        chk_cur("ff", 0, 0);
        chk("ff_queue", sb_q.size(), 0);

        // row 1 full of '1', cursor to (5,24), LF scrolls
        send_idle(8'h0A);
        for (int k = 0; k < 80; k++) begin
            push_w(80 + k, 8'h31);
            send_idle(8'h31);
        end
        chk_cur("row1_done", 0, 2);
        repeat (22) send_idle(8'h0A);
        chk_cur("last_row", 0, 24);
        for (int k = 0; k < 5; k++) begin
            push_w(1920 + k, 8'h78);
            send_idle(8'h78);
        end
        push_scroll(1920);
        send(8'h0A);
        started = 1'b0;
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge vclk);
            #1;
            if (!started && addr == 12'd80 && we == 1'b0)
                started = 1'b1;
            if (started) begin
                if (char_ready)
                    break;
                n++;
            end
        end
        chk("scroll_cycles", n, 3920);
        chk_cur("scroll", 5, 24);
        chk("scroll_queue", sb_q.size(), 0);
        bad = 0;
        for (int c = 0; c < 80; c++)
            if (mem[c] !== 8'h31) bad++;
        chk("row0_bad_cells", bad, 0);
        bad = 0;
        for (int c = 1920; c < 2000; c++)
            if (mem[c] !== 8'h20) bad++;
        chk("row24_bad_cells", bad, 0);
        bad = 0;
        for (int c = 1840; c < 1845; c++)
            if (mem[c] !== 8'h78) bad++;
        chk("row23_bad_cells", bad, 0);

        // reset during SCR_RD of index 500: writes 0..499 only, then full clear
        push_scroll(500);
        push_clear();
        send(8'h0A);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge vclk);
            #1;
            if (addr == 12'd580 && we == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_point_found", found, 1);
        rst = 1'b1;
        @(posedge vclk);
        #1;
        chk("abort_we", we, 0);
        rst = 1'b0;
        wait_ready(2200);
        chk_cur("abort", 0, 0);
        chk("abort_queue", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
